hamming_err_ctrl: RTL and testbench

HAMMING_ERR_CTRL -- requirements
Module: hamming_err_ctrl

---
 rtl/hamming_err_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_hamming_err_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_err_ctrl.sv
// -----------------------------------------------------------------------------
// hamming_err_ctrl
//
// Error-injection campaign controller for a Hamming(7,4) test path. It accepts
// a fixed number of codewords from the encoder and, for each accepted word,
// tells a registered bit-flip stage whether to flip a bit and which one. The
// flip stage has one cycle of latency, and out_valid is aligned to its output.
//
// Injection modes (latched at start):
//   0 none    : never inject
//   1 fixed   : inject at fixed_pos (fixed_pos = 7 disables injection)
//   2 walking : inject at a pointer that steps 0..6 and wraps
//   3 random  : inject at LFSR-1 (3-bit LFSR, x^3+x^2+1, period 7)
//
// Configuration macro:
//   HAMMING_ERR_LFSR_EN : when defined, mode 3 uses the LFSR. When undefined,
//                         no LFSR is built and mode 3 behaves as mode 0.
//
// Parameters:
//   CNT_W     : width of n_words, word_cnt and inj_cnt
//   LFSR_SEED : nonzero LFSR reload value
//
// Ports:
//   clk, rst           : clock (rising edge), asynchronous active-high reset
//   start              : begin a campaign (sampled in IDLE only)
//   stop               : abort a campaign (sampled in RUN only)
//   mode, fixed_pos,
//   n_words            : campaign configuration, latched at start
//   cw_valid, cw_ready : codeword handshake from the encoder
//   err_en, err_pos    : EN and bit position of the registered flip stage
//   out_valid          : flip stage output holds a campaign word this cycle
//   done               : one-cycle campaign completion pulse
//   word_cnt, inj_cnt  : words accepted / errors injected in this campaign
// -----------------------------------------------------------------------------
module hamming_err_ctrl #(
  parameter int unsigned CNT_W     = 8,
  parameter logic [2:0]  LFSR_SEED = 3'b001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [2:0]       fixed_pos,
  input  logic [CNT_W-1:0] n_words,
  input  logic             cw_valid,
  output logic             cw_ready,
  output logic             err_en,
  output logic [2:0]       err_pos,
  output logic             out_valid,
  output logic             done,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] inj_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {MODE_NONE, MODE_FIXED, MODE_WALK, MODE_RAND} mode_t;

  // Highest codeword bit index; the walking pointer wraps after it.
  localparam logic [2:0] LAST_POS   = 3'd6;
  // A fixed position of 7 points outside the 7-bit codeword: no injection.
  localparam logic [2:0] NO_INJ_POS = 3'd7;

  // An all-zero seed would lock the LFSR at zero forever.
  if (LFSR_SEED == 3'b000) begin : g_seed_check
    $error("hamming_err_ctrl: LFSR_SEED must be nonzero");
  end

  state_t           state_q, state_d;
  mode_t            mode_q;
  logic [2:0]       fixed_pos_q;
  logic [CNT_W-1:0] n_words_q;
  logic [2:0]       walk_ptr_q;

  logic             launch;
  logic             accept;
  logic             inject;
  logic [2:0]       sched_pos;
  logic [CNT_W-1:0] word_cnt_nxt;

  // ---------------------------------------------------------------------------
  // Handshake and schedule decode
  // ---------------------------------------------------------------------------
  assign launch       = (state_q == IDLE) && start;
  assign cw_ready     = (state_q == RUN) && (word_cnt < n_words_q);
  assign accept       = cw_valid && cw_ready;
  assign word_cnt_nxt = word_cnt + CNT_W'(accept);

`ifdef HAMMING_ERR_LFSR_EN
  logic [2:0] lfsr_q;

  // Fibonacci form of x^3+x^2+1: feedback = bit2 ^ bit1, shifted in at bit0.
  // Steps only on accepted words so the sequence is tied to words, not time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (launch) begin
      lfsr_q <= LFSR_SEED;
    end else if (accept) begin
      lfsr_q <= {lfsr_q[1:0], lfsr_q[2] ^ lfsr_q[1]};
    end
  end
`endif

  // Position and inject decision come only from latched config and schedule
  // registers; cw_valid enters only through accept when gating err_en.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so that
    // no path leaves it unassigned, which would infer a latch.
    inject    = 1'b0;
    sched_pos = 3'd0;
    case (mode_q)
      MODE_FIXED: begin
        inject    = (fixed_pos_q != NO_INJ_POS);
        sched_pos = fixed_pos_q;
      end
      MODE_WALK: begin
        inject    = 1'b1;
        sched_pos = walk_ptr_q;
      end
      MODE_RAND: begin
`ifdef HAMMING_ERR_LFSR_EN
        inject    = 1'b1;
        sched_pos = lfsr_q - 3'd1;
`else
        inject    = 1'b0;
        sched_pos = 3'd0;
`endif
      end
      default: begin
        inject    = 1'b0;
        sched_pos = 3'd0;
      end
    endcase
  end

  // The flip stage registers EN in the accept cycle, so EN must be
  // combinational from cw_valid. The position is forced to 0 when idle so the
  // flip stage never sees a stale index.
  assign err_en  = accept && inject;
  assign err_pos = err_en ? sched_pos : 3'd0;

  assign done = (state_q == DONE);

  // ---------------------------------------------------------------------------
  // Campaign FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        // Compare against the post-accept count so the last accept (or a stop
        // in the same cycle) moves straight to DRAIN, where its out_valid
        // appears. n_words = 0 leaves RUN on its first cycle.
        if (stop || (word_cnt_nxt == n_words_q)) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Latched configuration, schedule state and statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: config and counters are reset as well as reloaded at start, so a
    // reset mid-campaign leaves nothing stale visible on word_cnt/inj_cnt.
    if (rst) begin
      mode_q      <= MODE_NONE;
      fixed_pos_q <= 3'd0;
      n_words_q   <= '0;
      walk_ptr_q  <= 3'd0;
      word_cnt    <= '0;
      inj_cnt     <= '0;
      out_valid   <= 1'b0;
    end else begin
      // Mirrors the flip stage's single register so the two stay aligned.
      out_valid <= accept;
      if (launch) begin
        mode_q      <= mode_t'(mode);
        fixed_pos_q <= fixed_pos;
        n_words_q   <= n_words;
        walk_ptr_q  <= 3'd0;
        word_cnt    <= '0;
        inj_cnt     <= '0;
      end else if (accept) begin
        // word_cnt is bounded by n_words_q, so neither counter can wrap.
        word_cnt <= word_cnt_nxt;
        if (err_en) inj_cnt <= inj_cnt + CNT_W'(1);
        walk_ptr_q <= (walk_ptr_q == LAST_POS) ? 3'd0 : walk_ptr_q + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_hamming_err_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hamming_err_ctrl
//
// Table-driven bench for hamming_err_ctrl. Each table row is one campaign with
// its configuration, a cw_valid pattern, an optional stop point and the final
// counter values. A small behavioural model predicts cw_ready, err_en, err_pos,
// done and the counters every cycle; a scoreboard queue holds the cycle in
// which each accepted word must show up on out_valid. Hand-written sequences
// cover reset mid-campaign and restart afterwards.
// -----------------------------------------------------------------------------
module tb_hamming_err_ctrl;

  localparam int CNT_W = 8;

`ifdef HAMMING_ERR_LFSR_EN
  localparam bit LFSR_ON = 1'b1;
`else
  localparam bit LFSR_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [2:0]       fixed_pos;
  logic [CNT_W-1:0] n_words;
  logic             cw_valid;
  logic             cw_ready;
  logic             err_en;
  logic [2:0]       err_pos;
  logic             out_valid;
  logic             done;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] inj_cnt;

  always #5 clk = ~clk;

  hamming_err_ctrl #(
    .CNT_W     (CNT_W),
    .LFSR_SEED (3'b001)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .fixed_pos (fixed_pos),
    .n_words   (n_words),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .err_en    (err_en),
    .err_pos   (err_pos),
    .out_valid (out_valid),
    .done      (done),
    .word_cnt  (word_cnt),
    .inj_cnt   (inj_cnt)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [2:0]  fpos;
    int          n;
    logic [31:0] vmask;      // cw_valid per RUN-phase cycle, LSB first
    int          stop_after; // assert stop together with this accept (0 = never)
    bit          noise;      // wiggle start/stop/config where they must be ignored
    int          exp_wc;
    int          exp_ic;
  } vec_t;

  vec_t vecs[10];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural model state: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
  int m_state, m_mode, m_fpos, m_n, m_wc, m_ic, m_k;
  int sb_q[$];       // cycle numbers in which out_valid is due
  int done_seen;
  int pos_mask;
  int pos_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_inject();
    case (m_mode)
      1:       return (m_fpos != 7);
      2:       return 1'b1;
      3:       return LFSR_ON;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_mode = 0; m_fpos = 0; m_n = 0;
    m_wc = 0; m_ic = 0; m_k = 0;
    sb_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " cw_ready"},  cw_ready,  1'b0);
    check({tag, " err_en"},    err_en,    1'b0);
    check({tag, " err_pos"},   err_pos,   3'd0);
    check({tag, " out_valid"}, out_valid, 1'b0);
    check({tag, " done"},      done,      1'b0);
    check({tag, " word_cnt"},  word_cnt,  '0);
    check({tag, " inj_cnt"},   inj_cnt,   '0);
  endtask

  // One clock: compare at the falling edge, advance the model at the rising
  // edge using the same (stable) inputs, return 1 time unit after the edge.
  task automatic cycle();
    bit exp_ready, acc, inj, exp_ov;
    int exp_pos;
    @(negedge clk);
    cyc++;
    exp_ready = (m_state == 1) && (m_wc < m_n);
    acc       = cw_valid && exp_ready;
    inj       = m_inject();
    exp_pos   = (m_mode == 1) ? m_fpos : (m_k % 7);

    check("cw_ready", cw_ready, exp_ready);
    check("err_en",   err_en,   acc && inj);
    if (!(acc && inj))   check("err_pos idle", err_pos, 3'd0);
    else if (m_mode != 3) check("err_pos",      err_pos, exp_pos);
    if (err_en) begin
      pos_mask  |= (1 << err_pos);
      pos_count++;
    end
    check("done",     done,     m_state == 3);
    check("word_cnt", word_cnt, m_wc);
    check("inj_cnt",  inj_cnt,  m_ic);

    exp_ov = (sb_q.size() > 0) && (sb_q[0] == cyc);
    check("out_valid", out_valid, exp_ov);
    if (exp_ov) void'(sb_q.pop_front());
    if (acc) sb_q.push_back(cyc + 1);
    if (done) done_seen++;

    @(posedge clk);
    case (m_state)
      0: if (start) begin
        m_mode = mode; m_fpos = fixed_pos; m_n = n_words;
        m_wc = 0; m_ic = 0; m_k = 0; m_state = 1;
      end
      1: begin
        if (acc) begin
          m_wc++;
          m_k++;
          if (inj) m_ic++;
        end
        if (stop || (m_wc == m_n)) m_state = 2;
      end
      2:       m_state = 3;
      default: m_state = 0;
    endcase
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit finished;
    mode = v.mode; fixed_pos = v.fpos; n_words = CNT_W'(v.n);
    start = 1'b1; stop = 1'b0; cw_valid = 1'b0;
    pos_mask = 0; pos_count = 0; done_seen = 0;
    cycle();
    start    = 1'b0;
    finished = 1'b0;
    for (int i = 0; i < 64 && !finished; i++) begin
      cw_valid = (i < 32) ? v.vmask[i] : 1'b1;
      stop     = (v.stop_after > 0) && (m_state == 1) && (m_wc == v.stop_after - 1);
      if (v.noise) begin
        start     = 1'b1;
        mode      = 2'd0;
        fixed_pos = 3'd7;
        n_words   = '0;
        if (m_state != 1) stop = 1'b1;
      end
      cycle();
      if (m_state == 0) finished = 1'b1;
    end
    start = 1'b0; stop = 1'b0; cw_valid = 1'b0;
    check($sformatf("vec%0d finished in budget", idx), finished, 1'b1);
    check($sformatf("vec%0d done pulses", idx), done_seen, 1);
    check($sformatf("vec%0d final word_cnt", idx), word_cnt, v.exp_wc);
    check($sformatf("vec%0d final inj_cnt", idx), inj_cnt, v.exp_ic);
    if (v.mode == 2'd3) begin
      check($sformatf("vec%0d random position set", idx), pos_mask, LFSR_ON ? 32'h7F : 32'h0);
      check($sformatf("vec%0d random injections", idx), pos_count, LFSR_ON ? 7 : 0);
    end
  endtask

  initial begin
    //            mode  fpos  n   vmask          stop noise wc  ic
    vecs[0] = '{2'd0, 3'd0, 4,  32'hFFFF_FFFF, 0, 1'b0, 4,  0};
    vecs[1] = '{2'd2, 3'd0, 9,  32'hFFFF_FFFF, 0, 1'b0, 9,  9};
    vecs[2] = '{2'd1, 3'd3, 3,  32'hFFFF_FFFF, 0, 1'b0, 3,  3};
    vecs[3] = '{2'd1, 3'd7, 3,  32'hFFFF_FFFF, 0, 1'b0, 3,  0};
    vecs[4] = '{2'd3, 3'd0, 7,  32'hFFFF_FFFF, 0, 1'b0, 7,  LFSR_ON ? 7 : 0};
    vecs[5] = '{2'd0, 3'd0, 0,  32'hFFFF_FFFF, 0, 1'b0, 0,  0};
    vecs[6] = '{2'd2, 3'd0, 10, 32'hFFFF_FFFF, 3, 1'b0, 3,  3};
    vecs[7] = '{2'd2, 3'd0, 4,  32'hFFFF_FFFD, 0, 1'b0, 4,  4};
    vecs[8] = '{2'd1, 3'd5, 5,  32'hFFFF_FFF5, 0, 1'b1, 5,  5};
    vecs[9] = '{2'd2, 3'd0, 3,  32'hFFFF_FFFF, 0, 1'b0, 3,  3};

    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0;
    fixed_pos = 3'd0; n_words = '0; cw_valid = 1'b0;
    model_reset();
    #3;
    check_all_zero("power-on reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], i);
      cycle();
    end

    // Reset in the middle of a walking campaign with a word in flight.
    mode = 2'd2; fixed_pos = 3'd0; n_words = CNT_W'(10); start = 1'b1;
    done_seen = 0;
    cycle();
    start    = 1'b0;
    cw_valid = 1'b1;
    repeat (3) cycle();
    #2 rst = 1'b1;
    #1;
    check_all_zero("mid-campaign reset");
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    cw_valid = 1'b0;
    done_seen = 0;
    repeat (4) cycle();
    check("no done after reset", done_seen, 0);

    // Restart after the aborted campaign: walking pointer must begin at 0.
    run_vec(vecs[9], 9);
    check("restart first position", pos_mask & 32'h1, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
